// File: rtl/conv_output_collector_pkg.sv
// conv_output_collector_pkg: shared defaults, collector state encoding and width helper
package conv_output_collector_pkg;
  localparam int DEF_DATA_W = 25;
  localparam int DEF_MAP_W = 6;
  localparam int DEF_MAP_H = 6;
  localparam int DEF_FIFO_DEPTH = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/conv_output_collector_sync_fifo.sv
// sync_fifo: power-of-2 FIFO with registered count/full/empty and synchronous flush
module sync_fifo import conv_output_collector_pkg::*; #(
  parameter int WIDTH = DEF_DATA_W + 1,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0] r_count;
  logic w_push;
  logic w_pop;
  logic [AW:0] w_count;
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop = i_pop & ~o_empty & ~i_flush;
  assign w_count = i_flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign o_data = r_mem[r_rp];
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= i_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_count <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      r_wp <= i_flush ? '0 : r_wp + AW'(w_push);
      r_rp <= i_flush ? '0 : r_rp + AW'(w_pop);
      r_count <= w_count;
      o_full <= w_count == (AW+1)'(DEPTH);
      o_empty <= w_count == '0;
    end
  end
endmodule

// File: rtl/conv_output_collector.sv
// conv_output_collector: captures ok-qualified ReLU results once each, tags frame position, streams them out
module conv_output_collector import conv_output_collector_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAP_W = DEF_MAP_W,
  parameter int MAP_H = DEF_MAP_H,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_conv,
  input  logic [DATA_W-1:0] in,
  input  logic              ok,
  output logic              flag_out_,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              frame_done,
  output logic              frame_abort
);
  localparam int CW = MAP_W > 1 ? clog2(MAP_W) : 1;
  localparam int RW = MAP_H > 1 ? clog2(MAP_H) : 1;
  state_t r_state;
  state_t w_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic r_ack_pend;
  logic w_full;
  logic w_empty;
  logic w_cap;
  logic w_abort;
  logic w_col_end;
  logic w_last;
  logic w_pop;
  logic [DATA_W:0] w_head;
  assign w_cap = r_state == COLLECT & start_conv & ok & ~r_ack_pend & ~w_full;
  assign w_abort = r_state == COLLECT & ~start_conv;
  assign w_col_end = r_col == CW'(MAP_W - 1);
  assign w_last = w_col_end & (r_row == RW'(MAP_H - 1));
  assign w_pop = rd_valid & rd_ready;
  assign rd_valid = ~w_empty;
  assign rd_data = w_empty ? '0 : w_head[DATA_W-1:0];
  assign rd_last = ~w_empty & w_head[DATA_W];
  assign w_state = w_abort ? IDLE :
                   (r_state == IDLE & start_conv) ? COLLECT :
                   (w_cap & w_last) ? DONE :
                   (r_state == DONE & ~start_conv & w_empty) ? IDLE : r_state;
  sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_flush(w_abort),
    .i_push(w_cap),
    .i_pop(w_pop),
    .i_data({w_last, in}),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col <= '0;
      r_row <= '0;
      r_ack_pend <= 1'b0;
      flag_out_ <= 1'b0;
      frame_done <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      r_state <= w_state;
      r_col <= w_abort ? '0 : w_cap ? (w_col_end ? '0 : r_col + 1'b1) : r_col;
      r_row <= w_abort ? '0 : (w_cap & w_col_end) ? (w_last ? '0 : r_row + 1'b1) : r_row;
      r_ack_pend <= ~w_abort & (w_cap | (r_ack_pend & ok));
      flag_out_ <= w_cap;
      frame_done <= w_pop & rd_last;
      frame_abort <= w_abort & (r_col != '0 || r_row != '0);
    end
  end
endmodule

// File: tb/tb_conv_output_collector.sv
// tb_conv_output_collector: directed sequence with random data checked against a queue model
module tb_conv_output_collector;
  localparam int DW = 25;
  localparam int NPX = 4;
  localparam int NPX_B = 36;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_conv = 1'b0;
  logic ok = 1'b0;
  logic rd_ready = 1'b0;
  logic [DW-1:0] din = '0;
  logic flag_out_, rd_valid, rd_last, frame_done, frame_abort;
  logic [DW-1:0] rd_data;
  logic b_start = 1'b0;
  logic b_ok = 1'b0;
  logic b_ready = 1'b0;
  logic [DW-1:0] b_in = '0;
  logic b_flag, b_valid, b_last, b_done, b_abort;
  logic [DW-1:0] b_data;
  int checks = 0;
  int errors = 0;
  int n_flag = 0;
  int n_done = 0;
  int n_abort = 0;
  int nb_flag = 0;
  logic [DW:0] got[$];
  logic [DW:0] got_b[$];
  logic [DW:0] q_exp[$];
  logic [DW:0] q_exp_b[$];
  int g_base = 0;
  int n_px = 0;
  int n_px_b = 0;
  bit rnd_ready = 0;
  always #5 clk = ~clk;
  conv_output_collector #(.DATA_W(DW), .MAP_W(2), .MAP_H(2), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .in(din), .ok(ok),
    .flag_out_(flag_out_), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .frame_done(frame_done), .frame_abort(frame_abort)
  );
  conv_output_collector #(.DATA_W(DW), .MAP_W(6), .MAP_H(6), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .start_conv(b_start), .in(b_in), .ok(b_ok),
    .flag_out_(b_flag), .rd_valid(b_valid), .rd_ready(b_ready), .rd_data(b_data),
    .rd_last(b_last), .frame_done(b_done), .frame_abort(b_abort)
  );
  always @(negedge clk) if (!rst) begin
    if (flag_out_) n_flag++;
    if (frame_done) n_done++;
    if (frame_abort) n_abort++;
    if (rd_valid && rd_ready) got.push_back({rd_last, rd_data});
    if (b_flag) nb_flag++;
    if (b_valid && b_ready) got_b.push_back({b_last, b_data});
  end
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) rd_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic send(input logic [DW-1:0] v);
    bit seen;
    seen = 0;
    din = v;
    ok = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = flag_out_;
    end
    chk("ack", 64'(seen), 64'd1);
    if (seen) begin
      q_exp.push_back({n_px == NPX - 1, v});
      n_px = (n_px + 1) % NPX;
    end
    ok = 1'b0;
    tick();
  endtask
  task automatic send_b(input logic [DW-1:0] v);
    bit seen;
    seen = 0;
    b_in = v;
    b_ok = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = b_flag;
    end
    chk("ack_b", 64'(seen), 64'd1);
    if (seen) begin
      q_exp_b.push_back({n_px_b == NPX_B - 1, v});
      n_px_b = (n_px_b + 1) % NPX_B;
    end
    b_ok = 1'b0;
    tick();
  endtask
  task automatic cmp_q(input string tag);
    for (int k = 0; k < 100 && got.size() - g_base < q_exp.size(); k++) tick();
    tick();
    tick();
    chk({tag, "_count"}, 64'(got.size() - g_base), 64'(q_exp.size()));
    for (int i = 0; i < q_exp.size() && g_base + i < got.size(); i++)
      chk(tag, 64'(got[g_base + i]), 64'(q_exp[i]));
    g_base = got.size();
    q_exp.delete();
  endtask
  initial begin
    int f0, d0, a0;
    logic [DW-1:0] v9;
    rst = 1'b1;
    start_conv = 1'b1;
    ok = 1'b1;
    din = DW'($urandom);
    b_start = 1'b1;
    b_ok = 1'b1;
    b_in = DW'($urandom);
    rd_ready = 1'b1;
    b_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_ctrl", 64'({flag_out_, rd_valid, rd_last, frame_done, frame_abort}), 64'd0);
      chk("rst_data", 64'(rd_data), 64'd0);
      chk("rst_big", 64'({b_flag, b_valid, b_last, b_done, b_abort, b_data}), 64'd0);
    end
    rst = 1'b0;
    ok = 1'b0;
    start_conv = 1'b0;
    b_ok = 1'b0;
    b_start = 1'b0;
    b_ready = 1'b0;
    tick();
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("idle_ignores_ok", 64'({flag_out_, rd_valid}), 64'd0);
    end
    ok = 1'b0;
    tick();
    f0 = n_flag;
    d0 = n_done;
    start_conv = 1'b1;
    send(25'd5);
    send(25'd0);
    send(25'd7);
    send(25'd3);
    cmp_q("frame_5073");
    chk("frame_flags", 64'(n_flag - f0), 64'd4);
    chk("frame_done_once", 64'(n_done - d0), 64'd1);
    start_conv = 1'b0;
    tick();
    tick();
    a0 = n_abort;
    d0 = n_done;
    start_conv = 1'b1;
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(DW'($urandom));
    start_conv = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("done_no_flush", 64'(rd_valid), 64'd1);
    chk("done_no_abort", 64'(n_abort - a0), 64'd0);
    rnd_ready = 1;
    cmp_q("done_drain");
    rnd_ready = 0;
    rd_ready = 1'b1;
    chk("done_drain_done", 64'(n_done - d0), 64'd1);
    tick();
    f0 = n_flag;
    start_conv = 1'b1;
    tick();
    tick();
    din = 25'd9;
    ok = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("held_flag", 64'(flag_out_), 64'(k == 1));
    end
    ok = 1'b0;
    tick();
    q_exp.push_back({1'b0, 25'd9});
    n_px = 1;
    rnd_ready = 1;
    for (int k = 0; k < 3; k++) send(DW'($urandom));
    cmp_q("held_frame");
    rnd_ready = 0;
    rd_ready = 1'b1;
    chk("held_flags", 64'(n_flag - f0), 64'd4);
    start_conv = 1'b0;
    tick();
    tick();
    a0 = n_abort;
    start_conv = 1'b1;
    rd_ready = 1'b0;
    send(DW'($urandom));
    send(DW'($urandom));
    chk("abort_pre_valid", 64'(rd_valid), 64'd1);
    start_conv = 1'b0;
    tick();
    chk("abort_pulse", 64'(frame_abort), 64'd1);
    chk("abort_flushed", 64'(rd_valid), 64'd0);
    tick();
    chk("abort_one_cycle", 64'(frame_abort), 64'd0);
    q_exp.delete();
    n_px = 0;
    start_conv = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(DW'($urandom));
    cmp_q("restart_frame");
    chk("abort_count", 64'(n_abort - a0), 64'd1);
    start_conv = 1'b0;
    tick();
    tick();
    start_conv = 1'b1;
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(DW'($urandom));
    rst = 1'b1;
    tick();
    chk("midrst_flag", 64'(flag_out_), 64'd0);
    chk("midrst_empty", 64'(rd_valid), 64'd0);
    tick();
    rst = 1'b0;
    q_exp.delete();
    n_px = 0;
    g_base = got.size();
    rd_ready = 1'b1;
    for (int k = 0; k < 4; k++) send(DW'($urandom));
    cmp_q("post_rst_frame");
    f0 = nb_flag;
    b_start = 1'b1;
    b_ready = 1'b0;
    tick();
    for (int k = 0; k < 8; k++) send_b(DW'($urandom));
    chk("bp_full_valid", 64'(b_valid), 64'd1);
    v9 = DW'($urandom);
    b_in = v9;
    b_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_no_ack", 64'(b_flag), 64'd0);
    end
    b_ready = 1'b1;
    tick();
    chk("bp_pop_cycle_no_ack", 64'(b_flag), 64'd0);
    tick();
    chk("bp_capture_after_pop", 64'(b_flag), 64'd1);
    q_exp_b.push_back({1'b0, v9});
    n_px_b++;
    b_ok = 1'b0;
    tick();
    send_b(DW'($urandom));
    for (int k = 0; k < 100 && got_b.size() < q_exp_b.size(); k++) tick();
    tick();
    chk("bp_count", 64'(got_b.size()), 64'(q_exp_b.size()));
    for (int i = 0; i < q_exp_b.size() && i < got_b.size(); i++)
      chk("bp_order", 64'(got_b[i]), 64'(q_exp_b[i]));
    chk("bp_flags", 64'(nb_flag - f0), 64'd10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
